// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

  localparam int MAX_WORDS            = 64;
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rxd, samples each bit at mid-bit, LSB first.
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CLK = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state;
  logic [1:0]    sync;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_s;

  assign rx_s      = sync[1];
  assign byte_data = shift;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= R_IDLE;
      sync       <= 2'b11;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], rxd};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        R_IDLE: begin
          clk_cnt <= '0;
          if (!rx_s) state <= R_START;
        end
        R_START: begin
          if (clk_cnt == HALF_CLK) begin
            // A start bit that is no longer low at mid-bit was a glitch.
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= rx_s ? R_IDLE : R_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= R_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt    <= '0;
            state      <= R_IDLE;
            byte_valid <= rx_s;
            frame_err  <= !rx_s;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Receives a counted, XOR-checksummed image over UART and writes it into
// instruction memory, holding the CPU in reset until the image is verified.
module boot_loader
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  output logic        imem_write,
  output logic [7:0]  imem_address,
  output logic [31:0] imem_writedata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [6:0]  words_loaded
);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ferr;

  state_t      state;
  logic [7:0]  n_words;
  logic [6:0]  index;
  logic [6:0]  next_index;
  logic [1:0]  byte_cnt;
  logic [31:0] word;
  logic [7:0]  checksum;

  assign next_index = index + 7'd1;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rxd        (uart_rxd),
    .byte_data  (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_COUNT;
      n_words        <= '0;
      index          <= '0;
      byte_cnt       <= '0;
      word           <= '0;
      checksum       <= '0;
      imem_write     <= 1'b0;
      imem_address   <= '0;
      imem_writedata <= '0;
      cpu_hold       <= 1'b1;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
      words_loaded   <= '0;
    end else begin
      case (state)
        S_COUNT: if (rx_valid) begin
          n_words  <= rx_byte;
          checksum <= rx_byte;
          index    <= '0;
          byte_cnt <= '0;
          if (rx_byte == 8'd0) begin
            state <= S_CHECK;
          end else if (int'(rx_byte) > MAX_WORDS) begin
            state      <= S_ERROR;
            load_error <= 1'b1;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (rx_valid) begin
          checksum                      <= checksum ^ rx_byte;
          word[{byte_cnt, 3'b000} +: 8] <= rx_byte;
          byte_cnt                      <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            // The final byte goes straight into the write data so the
            // strobe can rise on the same edge that completes the word.
            state          <= S_WRITE;
            imem_write     <= 1'b1;
            imem_address   <= {index[5:0], 2'b00};
            imem_writedata <= {rx_byte, word[23:0]};
          end
        end
        S_WRITE: begin
          imem_write   <= 1'b0;
          index        <= next_index;
          words_loaded <= words_loaded + 7'd1;
          state        <= ({1'b0, next_index} == n_words) ? S_CHECK : S_DATA;
        end
        S_CHECK: if (rx_valid) begin
          if (rx_byte == checksum) begin
            state     <= S_DONE;
            cpu_hold  <= 1'b0;
            load_done <= 1'b1;
          end else begin
            state      <= S_ERROR;
            load_error <= 1'b1;
          end
        end
        default: ;
      endcase

      if (rx_ferr && state != S_DONE && state != S_ERROR) begin
        state      <= S_ERROR;
        load_error <= 1'b1;
        imem_write <= 1'b0;
      end
    end
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per UART bit (50 MHz / 115200).
REQ-003 The block SHALL have these ports:
  clk             in   1   system clock
  reset           in   1   async active-high reset
  uart_rxd        in   1   serial input, 8N1, idle high
  imem_write      out  1   instruction-memory write strobe
  imem_address    out  8   byte address of write, word-aligned
  imem_writedata  out  32  instruction word
  cpu_hold        out  1   holds processor in reset while high
  load_done       out  1   image loaded and checksum good
  load_error      out  1   count, framing or checksum failure
  words_loaded    out  7   completed word writes, 0..64

Function
REQ-004 Frame format SHALL be: count byte N, then N words of 4 bytes each, little-endian, then 1 checksum byte.
REQ-005 uart_rx SHALL pass uart_rxd through a 2-flop synchronizer, sample at mid-bit, and receive LSB first.
REQ-006 uart_rx SHALL pulse byte_valid for 1 cycle per byte; a low stop bit SHALL pulse frame_err instead.
REQ-007 The FSM states SHALL be S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE and S_ERROR.
REQ-008 In S_COUNT, N=0 SHALL go to S_CHECK, N in 1..64 SHALL go to S_DATA, and N>64 SHALL go to S_ERROR.
REQ-009 In S_DATA, byte k (0..3) SHALL load word bits [8k+7:8k]; on the 4th byte the FSM SHALL go to S_WRITE.
REQ-010 S_WRITE SHALL last exactly 1 cycle, driving imem_write=1, imem_address=4*index[5:0] and imem_writedata=the assembled word.
REQ-011 After S_WRITE, index and words_loaded SHALL increment; the FSM SHALL then go to S_CHECK if index==N, else to S_DATA.
REQ-012 The running checksum SHALL be the XOR of the count byte and all data bytes.
REQ-013 In S_CHECK, the received byte SHALL equal the running checksum to reach S_DONE; otherwise the FSM SHALL go to S_ERROR.
REQ-014 A frame_err in any state before S_DONE SHALL go to S_ERROR.
REQ-015 S_DONE and S_ERROR SHALL be terminal until reset; bytes received in them SHALL be ignored, with no writes.
REQ-016 cpu_hold SHALL be 1 in every state except S_DONE, and SHALL fall in the cycle S_DONE is entered.
REQ-017 load_done SHALL be 1 only in S_DONE, and load_error SHALL be 1 only in S_ERROR.
REQ-018 imem_address and imem_writedata SHALL hold their last values while imem_write is low.
REQ-019 The block SHALL make at most 1 write per 4 received bytes; a partial word SHALL never be written.

Reset
REQ-020 While reset is high, the FSM SHALL be in S_COUNT, and index, checksum, byte counter and uart_rx state SHALL be cleared.
REQ-021 While reset is high, the outputs SHALL be cpu_hold=1, imem_write=0, imem_address=0, imem_writedata=0, load_done=0, load_error=0 and words_loaded=0.
REQ-022 Reset mid-frame SHALL discard all partial bytes and words; the next start bit SHALL begin a fresh frame.

Structure
REQ-023 Package boot_pkg SHALL hold the FSM state enum, MAX_WORDS=64 and the CLKS_PER_BIT default.
REQ-024 The block SHALL contain one sub-module, uart_rx, with ports clk, reset, rxd, byte_data[7:0], byte_valid and frame_err.
REQ-025 The FSM, assembly and checksum logic SHALL stay in boot_loader.

Verification (bench uses CLKS_PER_BIT=8)
REQ-026 Send bytes 01 93 00 50 00 C2 -> one write (addr 0x00, data 0x00500093), words_loaded=1, load_done=1, cpu_hold=0.
REQ-027 Send N=02, two words, then a wrong checksum -> two writes (addr 0x00, 0x04), load_error=1, cpu_hold stays 1.
REQ-028 Send N=0x41 -> load_error=1 immediately, no imem_write pulse.
REQ-029 Send a low stop bit on the 3rd byte of the frame -> load_error=1, no write.
REQ-030 Assert reset after 2 data bytes, then send frame 01 13 00 00 00 12 -> single write, data 0x00000013, load_done=1.
REQ-031 Send N=0x40 with a valid checksum -> 64 writes, last at addr 0xFC, words_loaded=64, load_done=1.
